// File: rtl/modulo_varredura_matriz_neg_if.sv
// Frame input and LED matrix output bundle for the scanned matrix driver.
interface modulo_varredura_matriz_neg_if #(
  parameter int unsigned LINHAS   = 7,
  parameter int unsigned COLUNAS  = 5,
  parameter int unsigned DESCARTE = 1
);
  logic [LINHAS*COLUNAS+DESCARTE-1:0] m_at;
  logic                               carregar;
  logic                               habilitar;
  logic                               inverter;
  logic [LINHAS*COLUNAS-1:0]          N_m_at;
  logic [LINHAS-1:0]                  linhas;
  logic [COLUNAS-1:0]                 colunas;
  logic                               ocupado;
  logic                               fim_quadro;

  // Game-state side: drives frames and controls, observes the matrix pins.
  modport master (
    output m_at, carregar, habilitar, inverter,
    input  N_m_at, linhas, colunas, ocupado, fim_quadro
  );

  // Matrix driver side.
  modport slave (
    input  m_at, carregar, habilitar, inverter,
    output N_m_at, linhas, colunas, ocupado, fim_quadro
  );
endinterface

// File: rtl/modulo_varredura_matriz_neg.sv
// Double-buffered frame store with optional negation, scanned row by row
// onto an active-low LED matrix at a programmable refresh rate.
module modulo_varredura_matriz_neg #(
  parameter int unsigned LINHAS   = 7,
  parameter int unsigned COLUNAS  = 5,
  parameter int unsigned DESCARTE = 1,
  parameter int unsigned DIV      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  modulo_varredura_matriz_neg_if.slave   bus
);

  localparam int unsigned NB = LINHAS * COLUNAS;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RW = $clog2(LINHAS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(LINHAS - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [NB-1:0]      active_q, active_d;
  logic [NB-1:0]      shadow_q;
  logic [NB-1:0]      frame_in;
  logic               pend_q, pend_d;
  logic               tick_c, wrap_c;
  logic [COLUNAS-1:0] row_data_c;
  logic [LINHAS-1:0]  row_sel_c;

  assign frame_in = bus.m_at[DESCARTE +: NB];

  // Discarded LSBs of the input frame are intentionally ignored.
  if (DESCARTE > 0) begin : g_descarte
    logic unused_descarte;
    assign unused_descarte = ^bus.m_at[DESCARTE-1:0];
  end

  // Next-state for divider, row index and frame buffers; swap only at frame wrap.
  always_comb begin
    tick_c   = bus.habilitar && (cnt_q == CNT_MAX);
    wrap_c   = tick_c && (row_q == ROW_MAX);
    cnt_d    = cnt_q;
    row_d    = row_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (bus.habilitar) begin
      cnt_d = tick_c ? '0 : cnt_q + CW'(1);
    end
    if (tick_c) begin
      row_d = wrap_c ? '0 : row_q + RW'(1);
    end
    if (wrap_c) begin
      // A load coinciding with the wrap bypasses the shadow so it is not lost.
      if (bus.carregar) begin
        active_d = frame_in;
      end else if (pend_q) begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (bus.carregar) begin
      pend_d = 1'b1;
    end
  end

  // Select the data slice and one-hot strobe of the row shown after this edge.
  always_comb begin
    row_data_c = '0;
    row_sel_c  = '0;
    for (int r = 0; r < LINHAS; r++) begin
      if (row_d == RW'(r)) begin
        row_data_c   = active_d[r*COLUNAS +: COLUNAS];
        row_sel_c[r] = 1'b1;
      end
    end
  end

  // State and registered matrix outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      row_q          <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      pend_q         <= 1'b0;
      bus.N_m_at     <= '0;
      bus.colunas    <= '0;
      bus.linhas     <= '1;
      bus.ocupado    <= 1'b0;
      bus.fim_quadro <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      active_q       <= active_d;
      pend_q         <= pend_d;
      if (bus.carregar) begin
        shadow_q <= frame_in;
      end
      bus.N_m_at     <= active_d ^ {NB{bus.inverter}};
      bus.colunas    <= row_data_c ^ {COLUNAS{bus.inverter}};
      bus.linhas     <= bus.habilitar ? ~row_sel_c : '1;
      bus.ocupado    <= pend_d;
      bus.fim_quadro <= wrap_c;
    end
  end

endmodule

// File: tb/tb_modulo_varredura_matriz_neg.sv
// Randomized scoreboard bench for the scanned, negating matrix driver.
module tb_modulo_varredura_matriz_neg;

  localparam int unsigned L  = 7;
  localparam int unsigned C  = 5;
  localparam int unsigned DS = 1;
  localparam int unsigned DV = 4;
  localparam int unsigned NB = L * C;
  localparam int unsigned MW = NB + DS;
  localparam int         PERIOD_POS = DV * L;

  typedef struct packed {
    logic [NB-1:0] n;
    logic [L-1:0]  lin;
    logic [C-1:0]  col;
    logic          ocu;
    logic          fim;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Reference model: scan position as one integer over the whole frame period.
  int            mpos = 0;
  logic [NB-1:0] mact = '0;
  logic [NB-1:0] mshd = '0;
  logic          mocu = 1'b0;
  logic          cur_inv = 1'b1;

  modulo_varredura_matriz_neg_if #(.LINHAS(L), .COLUNAS(C), .DESCARTE(DS)) bus ();

  modulo_varredura_matriz_neg #(.LINHAS(L), .COLUNAS(C), .DESCARTE(DS), .DIV(DV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] rnd_m();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic c, input logic h, input logic i,
                      input logic [MW-1:0] m);
    exp_t          e;
    logic          wrap;
    logic [NB-1:0] frame;
    int            row;
    @(negedge clk);
    rst           = r;
    bus.carregar  = c;
    bus.habilitar = h;
    bus.inverter  = i;
    bus.m_at      = m;
    frame = m[MW-1:DS];
    wrap  = 1'b0;
    if (r) begin
      mpos = 0; mact = '0; mshd = '0; mocu = 1'b0;
    end else begin
      wrap = h && (mpos == PERIOD_POS - 1);
      if (h) mpos = (mpos + 1) % PERIOD_POS;
      if (wrap) begin
        if (c) mact = frame;
        else if (mocu) mact = mshd;
        mocu = 1'b0;
      end else if (c) begin
        mocu = 1'b1;
      end
      if (c) mshd = frame;
    end
    row   = mpos / DV;
    e.n   = r ? '0 : (mact ^ {NB{i}});
    e.col = r ? '0 : (C'(mact >> (row * C)) ^ {C{i}});
    e.lin = (r || !h) ? {L{1'b1}} : ~(L'(1) << row);
    e.ocu = mocu;
    e.fim = wrap;
    q.push_back(e);
  endtask

  task automatic run_to(input int tgt, input logic i);
    int n = 0;
    while (mpos != tgt && n < 200) begin
      step(1'b0, 1'b0, 1'b1, i, rnd_m());
      n++;
    end
    if (mpos != tgt) begin
      total++;
      bad++;
      $display("FAIL run_to: pos=%0d target=%0d", mpos, tgt);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("N_m_at",     64'(bus.N_m_at),     64'(e.n));
        chk("linhas",     64'(bus.linhas),     64'(e.lin));
        chk("colunas",    64'(bus.colunas),    64'(e.col));
        chk("ocupado",    64'(bus.ocupado),    64'(e.ocu));
        chk("fim_quadro", 64'(bus.fim_quadro), 64'(e.fim));
      end
    end
  end

  // Stimulus: directed scenarios followed by a random soak.
  initial begin
    int n;
    bus.m_at = '0; bus.carregar = 1'b0; bus.habilitar = 1'b0; bus.inverter = 1'b0;

    repeat (3) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_m());

    // Load then swap at the first wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 36'h000000003);
    repeat (40) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());

    // Inverter toggle mid-row, across a row boundary.
    run_to(6, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, rnd_m());
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());

    // Collision: load on the wrap-tick cycle.
    run_to(PERIOD_POS - 1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 36'hFFFFFFFFE);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());

    // Two loads before a wrap: the second one is shown.
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd_m());
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd_m());
    run_to(PERIOD_POS - 1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());

    // Disable mid row 3, then resume.
    run_to(3 * DV + 1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, rnd_m());
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_m());

    // Reset mid-scan with a pending load.
    run_to(10, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd_m());
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_m());
    repeat (35) step(1'b0, 1'b0, 1'b1, 1'b0, rnd_m());

    // Random soak.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) cur_inv = ~cur_inv;
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 7) != 0), cur_inv, rnd_m());
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
